// File: rtl/stream_mux4to1_rr_if.sv
// Handshake bundle for the 4-to-1 round-robin stream mux.
// It carries four valid/ready source channels and one registered output channel.
interface stream_mux4to1_rr_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0_data;
  logic [WIDTH-1:0] in1_data;
  logic [WIDTH-1:0] in2_data;
  logic [WIDTH-1:0] in3_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  // The master is the environment: it drives the sources and the downstream ready.
  modport master (
    output in0_data, in1_data, in2_data, in3_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  // The slave is the mux itself.
  modport slave (
    input  in0_data, in1_data, in2_data, in3_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux4to1_rr.sv
// Four valid/ready sources are merged onto one registered output by round-robin arbitration.
// The 2-bit source index travels alongside each word in out_sel.
module stream_mux4to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN,
  stream_mux4to1_rr_if.slave  bus
);

  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;
  logic             out_valid_q;
  logic [1:0]       last_q;

  logic             space;
  logic             load;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_data;

  assign space = !out_valid_q || bus.out_ready;
  assign load  = EN && space && (|bus.in_valid) && !rst;

  // Search starts one past the last winner and wraps. When nothing is valid,
  // grant is a don't-care because load is low.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = last_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = bus.in0_data;
    case (grant)
      2'd0:    grant_data = bus.in0_data;
      2'd1:    grant_data = bus.in1_data;
      2'd2:    grant_data = bus.in2_data;
      default: grant_data = bus.in3_data;
    endcase
  end

  assign bus.in_ready = load ? (4'b0001 << grant) : 4'b0000;

  // A load takes priority over a drain, so a simultaneous drain and load leaves no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
      last_q      <= 2'd3;
    end else if (load) begin
      out_data_q  <= grant_data;
      out_sel_q   <= grant;
      out_valid_q <= 1'b1;
      last_q      <= grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule
